// File: rtl/if_id_buf_pkg.sv
// Core definitions shared by the fetch/decode boundary: default bubble
// contents, the fetched pair record and the buffer occupancy encoding.
package if_id_buf_pkg;

  // addi x0,x0,0 -- architectural no-op used as the pipeline bubble
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  function automatic fetch_pkt_t make_pkt(input logic [31:0] addr,
                                          input logic [31:0] inst);
    fetch_pkt_t p;
    p.addr = addr;
    p.inst = inst;
    return p;
  endfunction

endpackage

// File: rtl/if_id_buf.sv
// Fetch-to-decode pipeline register with a 2-entry skid slot. Decode
// back-pressure is absorbed by the skid entry so in_ready_o comes only from
// registered state. A flush empties the buffer and presents a NOP bubble.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OCC_EMPTY | no valid entry; outputs show the bubble; ready to accept
// OCC_ONE   | head valid on outputs; skid free; ready to accept
// OCC_FULL  | head and skid valid; not ready until the head is consumed
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter logic [31:0] NOP_INST = INST_NOP,
  parameter logic [31:0] RST_ADDR = RST_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam fetch_pkt_t BUBBLE = '{addr: RST_ADDR, inst: NOP_INST};

  occ_t       occ_q;
  fetch_pkt_t head_q;
  fetch_pkt_t skid_q;
  logic       out_valid_q;
  logic       in_ready_q;

  fetch_pkt_t in_pkt;
  logic       push;
  logic       pop;

  assign in_pkt = make_pkt(inst_addr_i, inst_i);

  // Handshakes use only registered ready/valid, so no combinational path
  // runs from out_ready_i to in_ready_o.
  assign push = in_valid_i && in_ready_q && !flush_i;
  assign pop  = out_valid_q && out_ready_i;

  // Occupancy state machine; head/valid/ready are updated alongside the
  // state so every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      head_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush_i) begin
      // Skid contents are left as-is; they are unreachable once empty.
      occ_q       <= OCC_EMPTY;
      head_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_q      <= in_pkt;
            occ_q       <= OCC_ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_q <= in_pkt;
          end else if (push) begin
            skid_q     <= in_pkt;
            occ_q      <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            head_q      <= BUBBLE;
            occ_q       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        OCC_FULL: begin
          // push cannot occur here: in_ready_q is low while full
          if (pop) begin
            head_q     <= skid_q;
            occ_q      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to the empty state.
          occ_q       <= OCC_EMPTY;
          head_q      <= BUBBLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign inst_addr_o = head_q.addr;
  assign inst_o      = head_q.inst;
  assign out_valid_o = out_valid_q;
  assign in_ready_o  = in_ready_q;

`ifndef SYNTHESIS
  // Registered flags must always agree with the occupancy they summarise.
  a_ready_matches_occ : assert property (@(posedge clk) disable iff (!rst_n)
    in_ready_q == (occ_q != OCC_FULL));
  a_valid_matches_occ : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q == (occ_q != OCC_EMPTY));
  a_empty_is_bubble : assert property (@(posedge clk) disable iff (!rst_n)
    (occ_q == OCC_EMPTY) |-> (head_q == BUBBLE));
`endif

endmodule
